// File: rtl/av_udp_tx_reg_pkg.sv
// Shared constants for the Avalon-MM UDP payload transmitter: CSR map, CTRL bit
// positions and FSM state encoding.
package av_udp_tx_reg_pkg;

    localparam logic [3:0] ADDR_CTRL = 4'd0;
    localparam logic [3:0] ADDR_LEN  = 4'd9;

    localparam int CTRL_START  = 0;
    localparam int CTRL_BUSY   = 1;
    localparam int CTRL_DONE   = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_ERR    = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEND     = 2'd1;
    localparam logic [1:0] ST_COMPLETE = 2'd2;

    // A frame length is usable when it names at least one loaded word.
    function automatic logic len_is_valid(input logic [3:0] len, input logic [3:0] max_len);
        return (len != 4'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/av_udp_tx_reg.sv
// CSR-programmed payload buffer that streams LEN words to a UDP transmitter
// with sop/eop framing, a sticky DONE/ERR status and a level interrupt.
module av_udp_tx_reg
    import av_udp_tx_reg_pkg::*;
#(
    parameter int NUM_WORDS = 8,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [3:0]    address,
    input  logic          write,
    input  logic          read,
    input  logic [DW-1:0] writedata,
    output logic [DW-1:0] readdata,
    output logic          av_irq,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          tx_sop,
    output logic          tx_eop
);

    localparam logic [3:0] LAST_ADDR = 4'(NUM_WORDS);

    logic [DW-1:0] word_reg [NUM_WORDS];
    logic [3:0]    len_reg;
    logic [3:0]    idx_reg, idx_next;
    logic [1:0]    state_reg, state_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic          irq_en_reg;
    logic [DW-1:0] readdata_reg;
    logic [DW-1:0] rd_mux;
    logic [DW-1:0] ctrl_rd;

    logic busy;
    logic wr_ctrl;
    logic wr_len;
    logic wr_payload;
    logic start_req;
    logic last_beat;

    assign busy      = (state_reg != ST_IDLE);
    assign wr_ctrl   = write && (address == ADDR_CTRL);
    assign wr_len    = write && (address == ADDR_LEN) && !busy;
    // LEN owns address 9 even when NUM_WORDS would otherwise reach it.
    assign wr_payload = write && !busy && (address != ADDR_LEN)
                        && (address >= 4'd1) && (address <= LAST_ADDR);
    assign start_req = wr_ctrl && writedata[CTRL_START];

    assign tx_valid  = (state_reg == ST_SEND);
    assign tx_sop    = tx_valid && (idx_reg == 4'd0);
    assign last_beat = (idx_reg == len_reg - 4'd1);
    assign tx_eop    = tx_valid && last_beat;
    assign av_irq    = done_reg && irq_en_reg;
    assign readdata  = readdata_reg;

    always_comb begin
        tx_data = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (idx_reg == 4'(i)) begin
                tx_data = word_reg[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        done_next  = done_reg;
        err_next   = err_reg;
        if (wr_ctrl && writedata[CTRL_DONE]) begin
            done_next = 1'b0;
        end
        if (wr_ctrl && writedata[CTRL_ERR]) begin
            err_next = 1'b0;
        end
        // Status sets are evaluated after the W1C clears so a coincident set wins.
        case (state_reg)
            ST_IDLE: begin
                if (start_req) begin
                    if (len_is_valid(len_reg, LAST_ADDR)) begin
                        state_next = ST_SEND;
                        idx_next   = 4'd0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    idx_next = idx_reg + 4'd1;
                    if (last_beat) begin
                        state_next = ST_COMPLETE;
                    end
                end
            end
            ST_COMPLETE: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= 4'd0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            irq_en_reg <= 1'b0;
            len_reg    <= 4'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            if (wr_ctrl) begin
                irq_en_reg <= writedata[CTRL_IRQ_EN];
            end
            if (wr_len) begin
                len_reg <= writedata[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                word_reg[i] <= '0;
            end
        end else if (wr_payload) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (address == 4'(i + 1)) begin
                    word_reg[i] <= writedata;
                end
            end
        end
    end

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[CTRL_BUSY]   = busy;
        ctrl_rd[CTRL_DONE]   = done_reg;
        ctrl_rd[CTRL_IRQ_EN] = irq_en_reg;
        ctrl_rd[CTRL_ERR]    = err_reg;
    end

    // Unmapped addresses fall through to the held value.
    always_comb begin
        rd_mux = readdata_reg;
        if (address == ADDR_CTRL) begin
            rd_mux = ctrl_rd;
        end else if (address == ADDR_LEN) begin
            rd_mux = DW'(len_reg);
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (address == 4'(i + 1)) begin
                    rd_mux = word_reg[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
        end else if (read) begin
            readdata_reg <= rd_mux;
        end
    end

endmodule

// File: tb/tb_av_udp_tx_reg.sv
// Randomised self-checking bench for av_udp_tx_reg: CSR behaviour, framing,
// back-pressure, status races and asynchronous reset against a queue-based model.
module tb_av_udp_tx_reg;

    localparam int NW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    address = '0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] writedata = '0;
    logic [DW-1:0] readdata;
    logic          av_irq;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          tx_sop;
    logic          tx_eop;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t         beats[$];
    logic [DW-1:0] exp_words [NW];
    int            checks = 0;
    int            errors = 0;

    logic          hold_valid = 1'b0;
    beat_t         hold_beat;

    av_udp_tx_reg #(.NUM_WORDS(NW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .read(read), .writedata(writedata), .readdata(readdata), .av_irq(av_irq),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sop(tx_sop), .tx_eop(tx_eop)
    );

    always #5 clk = ~clk;

    // Stream monitor: records accepted beats and checks a stalled beat holds still.
    always @(negedge clk) begin
        if (!reset_n || !tx_valid) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                checks++;
                if ({tx_data, tx_sop, tx_eop} !== hold_beat) begin
                    errors++;
                    $display("FAIL stall_stable got=%h/%b/%b want=%h/%b/%b", tx_data, tx_sop, tx_eop,
                             hold_beat.data, hold_beat.sop, hold_beat.eop);
                end
            end
            if (tx_ready) begin
                beats.push_back('{data: tx_data, sop: tx_sop, eop: tx_eop});
                hold_valid = 1'b0;
            end else begin
                hold_valid = 1'b1;
                hold_beat  = '{data: tx_data, sop: tx_sop, eop: tx_eop};
            end
        end
    end

    task automatic av_write(input logic [3:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        address = a; writedata = d; write = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        $display("WR addr=%0d data=%h", a, d);
    endtask

    task automatic av_read(input logic [3:0] a, output logic [DW-1:0] d);
        @(posedge clk);
        #1;
        address = a; read = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        d = readdata;
        $display("RD addr=%0d data=%h", a, d);
    endtask

    task automatic load_words();
        for (int i = 0; i < NW; i++) begin
            av_write(4'(i + 1), exp_words[i]);
        end
    endtask

    // mode 0: ready held high, 1: ready toggles, 2: ready random.
    task automatic run_frame(input int len, input int mode, input string name);
        logic [DW-1:0] rd;
        load_words();
        av_write(4'd9, DW'(len));
        av_write(4'd0, 32'h4);
        tx_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        beats.delete();
        av_write(4'd0, 32'h9);
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency tx_valid=%b want=1", name, tx_valid);
        end
        for (int c = 0; c < 400 && beats.size() < len; c++) begin
            @(posedge clk);
            #1;
            if (mode == 1) tx_ready = ~tx_ready;
            else if (mode == 2) tx_ready = 1'($urandom_range(0, 1));
        end
        tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (beats.size() != len) begin
            errors++;
            $display("FAIL %s_count got=%0d want=%0d", name, beats.size(), len);
        end
        for (int i = 0; i < len && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== {exp_words[i], 1'(i == 0), 1'(i == len - 1)}) begin
                errors++;
                $display("FAIL %s_beat%0d got=%h/%b/%b want=%h/%b/%b", name, i, beats[i].data,
                         beats[i].sop, beats[i].eop, exp_words[i], i == 0, i == len - 1);
            end
        end
        av_read(4'd0, rd);
        checks++;
        if (rd !== 32'hC || av_irq !== 1'b1) begin
            errors++;
            $display("FAIL %s_status ctrl=%h irq=%b want ctrl=0000000c irq=1", name, rd, av_irq);
        end
        $display("FRAME %s len=%0d beats=%0d", name, len, beats.size());
    endtask

    task automatic test_reset();
        logic [DW-1:0] rd;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({readdata, tx_valid, tx_sop, tx_eop, av_irq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs rd=%h v=%b s=%b e=%b irq=%b want all 0",
                     readdata, tx_valid, tx_sop, tx_eop, av_irq);
        end
        #2 reset_n = 1'b1;
        av_read(4'd0, rd);
        checks++;
        if (rd !== '0) begin errors++; $display("FAIL reset_ctrl got=%h want=0", rd); end
        av_read(4'd9, rd);
        checks++;
        if (rd !== '0) begin errors++; $display("FAIL reset_len got=%h want=0", rd); end
        av_read(4'd3, rd);
        checks++;
        if (rd !== '0) begin errors++; $display("FAIL reset_word got=%h want=0", rd); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < NW; i++) exp_words[i] = DW'(32'h11 * (i + 1));
        run_frame(8, 0, "basic");
    endtask

    task automatic test_backpressure();
        run_frame(8, 1, "toggle");
    endtask

    task automatic test_len_error();
        logic [DW-1:0] rd;
        int bad_len;
        for (int k = 0; k < 2; k++) begin
            bad_len = (k == 0) ? 0 : $urandom_range(NW + 1, 15);
            av_write(4'd0, 32'h4);
            av_write(4'd9, DW'(bad_len));
            beats.delete();
            tx_ready = 1'b1;
            av_write(4'd0, 32'h1);
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                checks++;
                if (tx_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL lenerr_valid len=%0d tx_valid=%b want=0", bad_len, tx_valid);
                end
            end
            av_read(4'd0, rd);
            checks++;
            if (rd !== 32'h10) begin
                errors++;
                $display("FAIL lenerr_ctrl len=%0d got=%h want=00000010", bad_len, rd);
            end
            av_write(4'd0, 32'h10);
            av_read(4'd0, rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL lenerr_clear got=%h want=0", rd);
            end
        end
    endtask

    task automatic test_write_during_send();
        logic [DW-1:0] rd;
        for (int i = 0; i < NW; i++) exp_words[i] = DW'(32'h11 * (i + 1));
        load_words();
        av_write(4'd9, 32'd8);
        av_write(4'd0, 32'h4);
        tx_ready = 1'b0;
        beats.delete();
        av_write(4'd0, 32'h9);
        av_write(4'd2, 32'hDEAD);
        av_write(4'd9, 32'd3);
        av_write(4'd0, 32'h9);
        tx_ready = 1'b1;
        for (int c = 0; c < 100 && beats.size() < 8; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (beats.size() != 8) begin
            errors++;
            $display("FAIL wds_count got=%0d want=8", beats.size());
        end
        for (int i = 0; i < 8 && i < beats.size(); i++) begin
            checks++;
            if (beats[i].data !== exp_words[i]) begin
                errors++;
                $display("FAIL wds_beat%0d got=%h want=%h", i, beats[i].data, exp_words[i]);
            end
        end
        av_read(4'd2, rd);
        checks++;
        if (rd !== exp_words[1]) begin errors++; $display("FAIL wds_word1 got=%h want=%h", rd, exp_words[1]); end
        av_read(4'd9, rd);
        checks++;
        if (rd !== 32'd8) begin errors++; $display("FAIL wds_len got=%h want=8", rd); end
        av_read(4'd0, rd);
        checks++;
        if (rd !== 32'hC) begin errors++; $display("FAIL wds_ctrl got=%h want=0000000c", rd); end
    endtask

    task automatic test_done_race();
        logic [DW-1:0] rd;
        exp_words[0] = $urandom();
        av_write(4'd1, exp_words[0]);
        av_write(4'd9, 32'd1);
        av_write(4'd0, 32'h4);
        tx_ready = 1'b1;
        beats.delete();
        av_write(4'd0, 32'h9);
        @(posedge clk);
        #1;
        address = 4'd0; writedata = 32'hC; write = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        av_read(4'd0, rd);
        checks++;
        if (rd !== 32'hC) begin errors++; $display("FAIL race_done got=%h want=0000000c", rd); end
        checks++;
        if (beats.size() != 1 || beats[0] !== {exp_words[0], 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL race_single_beat count=%0d want 1 beat data=%h sop=1 eop=1", beats.size(), exp_words[0]);
        end
        av_write(4'd0, 32'hC);
        av_read(4'd0, rd);
        checks++;
        if (rd !== 32'h8 || av_irq !== 1'b0) begin
            errors++;
            $display("FAIL race_w1c ctrl=%h irq=%b want ctrl=00000008 irq=0", rd, av_irq);
        end
    endtask

    task automatic test_random_frames();
        int len;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NW; i++) exp_words[i] = $urandom();
            len = (f == 0) ? 1 : $urandom_range(1, NW);
            run_frame(len, 2, "random");
        end
    endtask

    task automatic test_reset_mid_send();
        logic [DW-1:0] rd;
        for (int i = 0; i < NW; i++) exp_words[i] = $urandom();
        load_words();
        av_write(4'd9, 32'd8);
        tx_ready = 1'b1;
        beats.delete();
        av_write(4'd0, 32'h9);
        for (int c = 0; c < 50 && beats.size() < 3; c++) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({tx_valid, tx_sop, tx_eop, av_irq} !== 4'b0 || readdata !== '0) begin
            errors++;
            $display("FAIL rst_async v=%b s=%b e=%b irq=%b rd=%h want all 0",
                     tx_valid, tx_sop, tx_eop, av_irq, readdata);
        end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        for (int a = 0; a <= 9; a++) begin
            av_read(4'(a), rd);
            checks++;
            if (rd !== '0) begin errors++; $display("FAIL rst_csr addr=%0d got=%h want=0", a, rd); end
        end
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_no_resume tx_valid=%b want=0", tx_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len_error();
        test_write_during_send();
        test_done_race();
        test_random_frames();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/av_udp_tx_reg.md
AV_UDP_TX_REG -- requirements
Module: av_udp_tx_reg

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 8, payload word count (1..15).
REQ-002 SHALL have parameter DW, default 32, payload/CSR data width.
REQ-003 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port address, input, 4, Avalon-MM word address.
REQ-006 SHALL have port write, input, 1, Avalon-MM write strobe.
REQ-007 SHALL have port read, input, 1, Avalon-MM read strobe.
REQ-008 SHALL have port writedata, input, DW, Avalon-MM write data.
REQ-009 SHALL have port readdata, output, DW, Avalon-MM read data, registered.
REQ-010 SHALL have port av_irq, output, 1, level interrupt.
REQ-011 SHALL have port tx_data, output, DW, stream payload word.
REQ-012 SHALL have port tx_valid, output, 1, stream beat valid.
REQ-013 SHALL have port tx_ready, input, 1, downstream UDP transmitter accepts beat.
REQ-014 SHALL have port tx_sop / tx_eop, output, 1 each, first / last beat markers.

Function
REQ-015 SHALL decode the map: 0 CTRL, 1..NUM_WORDS payload word[addr-1], 9 LEN (bits [3:0]); other addresses: writes ignored, reads hold readdata.
REQ-016 SHALL lay out CTRL as: bit0 START (W1, reads 0), bit1 BUSY (RO), bit2 DONE (sticky, W1C), bit3 IRQ_EN (RW), bit4 ERR (sticky, W1C), bits[DW-1:5] read 0.
REQ-017 SHALL return readdata one cycle after read is sampled; without read, readdata holds its last value.
REQ-018 SHALL ignore payload and LEN writes while BUSY=1.
REQ-019 SHALL implement FSM IDLE, SEND, COMPLETE; reset state is IDLE.
REQ-020 IDLE->SEND on a START write when 1<=LEN<=NUM_WORDS; the word index is cleared to 0.
REQ-021 SHALL ignore a START write with LEN=0 or LEN>NUM_WORDS, set ERR, and remain in IDLE.
REQ-022 SHALL ignore a START write while in SEND or COMPLETE; ERR is unchanged.
REQ-023 In SEND: tx_valid=1, tx_data=word[idx], tx_sop=(idx==0), tx_eop=(idx==LEN-1); tx_data/sop/eop stay stable until accepted.
REQ-024 SHALL accept a beat on tx_valid&tx_ready and increment idx; on acceptance with tx_eop, move to COMPLETE.
REQ-025 COMPLETE SHALL last exactly one cycle, set DONE, and return to IDLE; tx_valid=0.
REQ-026 SHALL hold BUSY=1 in SEND and COMPLETE, and 0 in IDLE.
REQ-027 If DONE set and W1C clear occur in the same cycle, set SHALL win (same rule for ERR).
REQ-028 SHALL drive av_irq = DONE & IRQ_EN, combinational from registered bits.
REQ-029 With LEN=1 the single beat SHALL assert tx_sop and tx_eop together.
REQ-030 Minimum latency: START write at cycle N gives tx_valid=1 at cycle N+1.

Reset
REQ-031 On reset_n=0: FSM IDLE, idx 0, all payload words 0, LEN 0, CTRL 0, readdata 0, tx_valid/tx_sop/tx_eop 0, av_irq 0.
REQ-032 Reset asserted mid-SEND SHALL drop tx_valid immediately (asynchronous); there is no resumption after release.

Structure
REQ-033 Shared package SHALL hold the CSR address constants, CTRL bit indices, and FSM state encoding.
REQ-034 SHALL be a single module with no sub-module; the register file is an internal array of NUM_WORDS x DW.

Verification
REQ-035 Write words 0x11..0x88, LEN=8, IRQ_EN+START; tx_ready=1 -> 8 consecutive beats 0x11..0x88, sop on beat 0, eop on beat 7, then DONE=1 and av_irq=1.
REQ-036 Same as REQ-035 with tx_ready toggling 1/0 -> no beat lost or duplicated; tx_data stable while tx_ready=0.
REQ-037 LEN=0 then START -> no tx_valid, ERR=1, BUSY=0; write CTRL bit4=1 -> ERR=0.
REQ-038 Write word1=0xDEAD during SEND -> transmitted word1 keeps its old value; readback of addr 2 after DONE returns the old value.
REQ-039 DONE W1C issued in the same cycle as COMPLETE -> DONE stays 1.
REQ-040 reset_n pulsed low on beat 3 -> tx_valid=0 at once; all CSRs read 0 after release.
